// File: rtl/nn_pkg.sv
// ============================================================================
// Module : nn_pkg
// Brief  : Shared FSM state type, default layer constants and the signed
//          saturation helper for the sequential neural-network layer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nn_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      MAC  = 2'd2,
      EMIT = 2'd3
   } nn_state_t;

   localparam int NN_N_IN_DEF   = 16;
   localparam int NN_N_OUT_DEF  = 2;
   localparam int NN_DATA_W_DEF = 32;
   localparam int NN_FRAC_W_DEF = 16;

   // Working widths of the saturation helper; callers size-cast in and out.
   localparam int SAT_IN_W  = 256;
   localparam int SAT_OUT_W = 64;

   function automatic logic [SAT_OUT_W-1:0] nn_saturate(
      input logic signed [SAT_IN_W-1:0] v,
      input int unsigned                dw
   );
      logic signed [SAT_IN_W-1:0] maxv;
      logic signed [SAT_IN_W-1:0] minv;
      logic signed [SAT_IN_W-1:0] res;
      maxv = (SAT_IN_W'(1) <<< (dw - 1)) - SAT_IN_W'(1);
      minv = -maxv - SAT_IN_W'(1);
      if (v > maxv)      res = maxv;
      else if (v < minv) res = minv;
      else               res = v;
      return SAT_OUT_W'(res);
   endfunction

endpackage

`default_nettype wire

// File: rtl/nn_mac.sv
// ============================================================================
// Module : nn_mac
// Brief  : Registered multiply-accumulate with bias preload and saturating,
//          optionally ReLU'd (macro NN_RELU_EN) result register.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_mac
   import nn_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W_DEF,
   parameter int FRAC_W = NN_FRAC_W_DEF,
   parameter int N_IN   = NN_N_IN_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              en_i,
   input  logic              first_i,
   input  logic              last_i,
   input  logic [DATA_W-1:0] bias_i,
   input  logic [DATA_W-1:0] w_i,
   input  logic [DATA_W-1:0] x_i,
   output logic [DATA_W-1:0] result_o
);

   localparam int PROD_W = 2 * DATA_W;
   localparam int ACC_W  = 2 * DATA_W + $clog2(N_IN + 1);

   logic signed [ACC_W-1:0]  acc_q;
   logic signed [ACC_W-1:0]  acc_base;
   logic signed [ACC_W-1:0]  acc_d;
   logic signed [ACC_W-1:0]  shifted;
   logic signed [PROD_W-1:0] prod;
   logic [DATA_W-1:0]        sat_val;
   logic [DATA_W-1:0]        result_d;
   logic [DATA_W-1:0]        result_q;

   // The first cycle of a neuron seeds the accumulator with the bias and
   // adds the first product in the same cycle.
   always_comb begin
      prod     = PROD_W'($signed(w_i)) * PROD_W'($signed(x_i));
      acc_base = first_i ? (ACC_W'($signed(bias_i)) <<< FRAC_W) : acc_q;
      acc_d    = acc_base + ACC_W'(prod);
      shifted  = acc_d >>> FRAC_W;
      sat_val  = DATA_W'(nn_saturate(SAT_IN_W'(shifted), DATA_W));
`ifdef NN_RELU_EN
      result_d = sat_val[DATA_W-1] ? '0 : sat_val;
`else
      result_d = sat_val;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         acc_q    <= '0;
         result_q <= '0;
      end else if (en_i) begin
         acc_q <= acc_d;
         if (last_i) result_q <= result_d;
      end
   end

   assign result_o = result_q;

endmodule

`default_nettype wire

// File: rtl/nn_layer_seq.sv
// ============================================================================
// Module : nn_layer_seq
// Brief  : Sequential fully-connected layer: buffers N_IN samples, then
//          computes N_OUT neurons one MAC per cycle. Macro NN_RELU_EN adds ReLU.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_layer_seq
   import nn_pkg::*;
#(
   parameter int N_IN   = NN_N_IN_DEF,
   parameter int N_OUT  = NN_N_OUT_DEF,
   parameter int DATA_W = NN_DATA_W_DEF,
   parameter int FRAC_W = NN_FRAC_W_DEF
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                w_we,
   input  logic [$clog2(N_OUT*(N_IN+1))-1:0]   w_addr,
   input  logic [DATA_W-1:0]                   w_data,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [DATA_W-1:0]                   in_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [DATA_W-1:0]                   out_data,
   output logic                                busy
);

   localparam int DEPTH = N_OUT * (N_IN + 1);
   localparam int AW    = $clog2(DEPTH);
   localparam int KW    = $clog2(N_IN);
   localparam int OW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N_IN - 1);
   localparam logic [OW-1:0] O_LAST = OW'(N_OUT - 1);

   nn_state_t         state_q;
   logic [KW-1:0]     k_q;
   logic [OW-1:0]     o_q;
   logic              out_valid_q;
   logic              in_ready_q;
   logic              busy_q;
   logic [DATA_W-1:0] x_q    [N_IN];
   logic [DATA_W-1:0] wmem_q [DEPTH];
   logic [AW-1:0]     w_idx;
   logic [AW-1:0]     b_idx;

   // Storage is intentionally not reset; weights survive reset.
   always_ff @(posedge clk) begin
      if (state_q == IDLE && w_we && 32'(w_addr) < DEPTH)
         wmem_q[w_addr] <= w_data;
   end

   always_ff @(posedge clk) begin
      if (in_valid && (state_q == IDLE || state_q == LOAD))
         x_q[k_q] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         k_q         <= '0;
         o_q         <= '0;
         out_valid_q <= 1'b0;
         in_ready_q  <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (in_valid) begin
               k_q     <= KW'(1);
               busy_q  <= 1'b1;
               state_q <= LOAD;
            end
            LOAD: if (in_valid) begin
               if (k_q == K_LAST) begin
                  k_q        <= '0;
                  o_q        <= '0;
                  in_ready_q <= 1'b0;
                  state_q    <= MAC;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            MAC: begin
               if (k_q == K_LAST) begin
                  k_q         <= '0;
                  out_valid_q <= 1'b1;
                  state_q     <= EMIT;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            EMIT: if (out_ready) begin
               out_valid_q <= 1'b0;
               if (o_q == O_LAST) begin
                  o_q        <= '0;
                  in_ready_q <= 1'b1;
                  busy_q     <= 1'b0;
                  state_q    <= IDLE;
               end else begin
                  o_q     <= o_q + OW'(1);
                  state_q <= MAC;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign w_idx = AW'(32'(o_q) * (N_IN + 1) + 32'(k_q));
   assign b_idx = AW'(32'(o_q) * (N_IN + 1) + N_IN);

   nn_mac #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .N_IN   (N_IN)
   ) u_mac (
      .clk      (clk),
      .reset    (reset),
      .en_i     (state_q == MAC),
      .first_i  (k_q == '0),
      .last_i   (k_q == K_LAST),
      .bias_i   (wmem_q[b_idx]),
      .w_i      (wmem_q[w_idx]),
      .x_i      (x_q[k_q]),
      .result_o (out_data)
   );

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_nn_layer_seq.sv
// ============================================================================
// Module : tb_nn_layer_seq
// Brief  : Self-checking bench for nn_layer_seq (N_IN=4, N_OUT=2, Q16.16).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nn_layer_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        w_we;
   logic [3:0]  w_addr;
   logic [31:0] w_data;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q [$];

   typedef struct packed {
      logic [3:0][31:0] w0;
      logic [31:0]      b0;
      logic [3:0][31:0] w1;
      logic [31:0]      b1;
      logic [3:0][31:0] x;
      logic [31:0]      e0;
      logic [31:0]      e1;
   } vec_t;

   vec_t tbl [5];

   always #5 clk = ~clk;

   nn_layer_seq #(.N_IN(4), .N_OUT(2), .DATA_W(32), .FRAC_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .w_we      (w_we),
      .w_addr    (w_addr),
      .w_data    (w_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   function automatic logic [3:0][31:0] mk4(input logic [31:0] a, b, c, d);
      return {d, c, b, a};
   endfunction

   function automatic logic [31:0] act(input logic [31:0] v);
`ifdef NN_RELU_EN
      return v[31] ? 32'h0 : v;
`else
      return v;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, a, e);
      end
   endtask

   // Scoreboard: a handshake happens at the next posedge when both are high.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_output actual=%h expected=none", out_data);
         end else begin
            chk("out_data", out_data, exp_q.pop_front());
         end
      end
   end

   task automatic wr(input int addr, input logic [31:0] data);
      w_we = 1'b1; w_addr = 4'(addr); w_data = data;
      @(posedge clk); #1;
      w_we = 1'b0;
   endtask

   task automatic load_vec(input vec_t v);
      for (int i = 0; i < 4; i++) wr(i, v.w0[i]);
      wr(4, v.b0);
      for (int i = 0; i < 4; i++) wr(5 + i, v.w1[i]);
      wr(9, v.b1);
   endtask

   task automatic feed(input logic [3:0][31:0] x);
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = x[i];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d pending expected=0", exp_q.size());
         exp_q.delete();
      end
      @(posedge clk); #1;
      chk("idle_busy", busy, 0);
      chk("idle_in_ready", in_ready, 1);
   endtask

   initial begin
      tbl[0] = '{w0: mk4(32'h10000, 32'h10000, 32'h10000, 32'h10000), b0: 32'h8000,
                 w1: mk4(32'h10000, 32'h10000, 32'h10000, 32'h10000), b1: 32'h0,
                 x:  mk4(32'h10000, 32'h20000, 32'h30000, 32'h40000),
                 e0: 32'h000A8000, e1: 32'h000A0000};
      tbl[1] = '{w0: mk4(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000), b0: 32'h0,
                 w1: mk4(32'h0, 32'h0, 32'h0, 32'h0), b1: 32'h12345678,
                 x:  mk4(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000),
                 e0: 32'h7FFFFFFF, e1: 32'h12345678};
      tbl[2] = '{w0: mk4(32'h80010000, 32'h80010000, 32'h80010000, 32'h80010000), b0: 32'h0,
                 w1: mk4(32'h0, 32'h0, 32'h0, 32'h0), b1: 32'hFFFF8000,
                 x:  mk4(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000),
                 e0: 32'h80000000, e1: 32'hFFFF8000};
      tbl[3] = '{w0: mk4(32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000, 32'hFFFF0000), b0: 32'h0,
                 w1: mk4(32'h20000, 32'hFFFF0000, 32'h8000, 32'h1), b1: 32'h100,
                 x:  mk4(32'h10000, 32'h10000, 32'h10000, 32'h10000),
                 e0: 32'hFFFC0000, e1: 32'h00018101};
      tbl[4] = '{w0: mk4(32'h1, 32'h0, 32'h0, 32'h0), b0: 32'h0,
                 w1: mk4(32'h10000, 32'h10000, 32'h10000, 32'h10000), b1: 32'h0,
                 x:  mk4(32'hFFFFFFFF, 32'h1, 32'h10000, 32'h0),
                 e0: 32'hFFFFFFFF, e1: 32'h00010000};

      reset = 1'b1; w_we = 1'b0; w_addr = '0; w_data = '0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_in_ready", in_ready, 1);

      // Table vectors; the first one also checks output latency.
      for (int t = 0; t < 5; t++) begin
         load_vec(tbl[t]);
         exp_q.push_back(act(tbl[t].e0));
         exp_q.push_back(act(tbl[t].e1));
         feed(tbl[t].x);
         if (t == 0) begin
            for (int c = 1; c <= 3; c++) begin
               @(posedge clk); #1;
               chk("lat_early_valid", out_valid, 0);
               chk("mac_in_ready", in_ready, 0);
               chk("mac_busy", busy, 1);
            end
            @(posedge clk); #1;
            chk("lat_valid", out_valid, 1);
         end
         drain();
      end

      // Backpressure: result held while out_ready is low.
      load_vec(tbl[0]);
      out_ready = 1'b0;
      exp_q.push_back(32'h000A8000);
      exp_q.push_back(32'h000A0000);
      feed(tbl[0].x);
      begin
         int n = 0;
         while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      end
      chk("bp_valid", out_valid, 1);
      for (int c = 0; c < 10; c++) begin
         @(posedge clk); #1;
         chk("bp_hold_data", out_data, 32'h000A8000);
      end
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_busy", busy, 1);
      out_ready = 1'b1;
      drain();

      // Reset mid-MAC discards the partial inference.
      load_vec(tbl[1]);
      feed(tbl[1].x);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rst2_busy", busy, 0);
      chk("rst2_in_ready", in_ready, 1);
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         chk("rst2_no_valid", out_valid, 0);
      end
      load_vec(tbl[0]);
      exp_q.push_back(32'h000A8000);
      exp_q.push_back(32'h000A0000);
      feed(tbl[0].x);
      drain();

      // Weight writes and stray samples while busy are ignored.
      exp_q.push_back(32'h000A8000);
      exp_q.push_back(32'h000A0000);
      feed(tbl[0].x);
      w_we = 1'b1; w_data = 32'h0; in_valid = 1'b1; in_data = 32'hDEADBEEF;
      for (int c = 0; c < 8; c++) begin
         w_addr = 4'(c);
         @(posedge clk); #1;
      end
      w_we = 1'b0; in_valid = 1'b0;
      drain();
      exp_q.push_back(32'h000A8000);
      exp_q.push_back(32'h000A0000);
      feed(tbl[0].x);
      drain();

      // Out-of-range addresses dropped; a write on the first accept lands.
      for (int a = 10; a < 16; a++) wr(a, 32'h0);
      exp_q.push_back(act(32'h000B8000));
      exp_q.push_back(32'h000A0000);
      w_we = 1'b1; w_addr = 4'd4; w_data = 32'h00018000;
      in_valid = 1'b1; in_data = tbl[0].x[0];
      @(posedge clk); #1;
      w_we = 1'b0;
      for (int i = 1; i < 4; i++) begin
         in_data = tbl[0].x[i];
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire

// File: doc/nn_layer_seq.md
NN_LAYER_SEQ -- requirements
Module: nn_layer_seq

Interface
REQ-001 Parameter N_IN, default 16: inputs per neuron (>=2).
REQ-002 Parameter N_OUT, default 2: neurons (outputs) per layer (>=1).
REQ-003 Parameter DATA_W, default 32: signed fixed-point word width.
REQ-004 Parameter FRAC_W, default 16: fractional bits (Q(DATA_W-FRAC_W).FRAC_W).
REQ-005 Ports, in this order:
- clk  in  1  clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- w_we  in  1  weight/bias write strobe.
- w_addr  in  $clog2(N_OUT*(N_IN+1))  weight address: o*(N_IN+1)+i; i==N_IN selects the bias of neuron o.
- w_data  in  DATA_W  weight/bias value.
- in_valid  in  1  input sample valid.
- in_ready  out  1  input sample accepted when valid&&ready.
- in_data  in  DATA_W  input sample; samples arrive in order X_1..X_N_IN.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when valid&&ready.
- out_data  out  DATA_W  neuron result, in order O_1..O_N_OUT.
- busy  out  1  high in any state except IDLE.

Function
REQ-006 The FSM SHALL have states IDLE, LOAD, MAC, EMIT.
REQ-007 In IDLE and LOAD, in_ready SHALL be 1; in MAC and EMIT it SHALL be 0.
REQ-008 An accepted sample SHALL be stored in input buffer slot k, where k counts 0..N_IN-1; IDLE->LOAD on the first accept; LOAD->MAC on the accept of slot N_IN-1.
REQ-009 MAC SHALL perform one multiply-accumulate per cycle for neuron o: acc += W[o][k]*X[k], k=0..N_IN-1, for exactly N_IN cycles.
REQ-010 The accumulator SHALL be 2*DATA_W+$clog2(N_IN+1) bits signed. It SHALL be initialised to bias<<FRAC_W in the first MAC cycle of each neuron, so that the first product is added in that same cycle.
REQ-011 The result SHALL be acc arithmetically shifted right by FRAC_W (truncation toward -inf). It SHALL then be saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-012 MAC->EMIT after N_IN cycles. out_valid SHALL rise on the cycle after the last MAC cycle, i.e. N_IN+1 cycles after the final input accept for neuron 0.
REQ-013 In EMIT, out_valid and out_data SHALL be held stable until out_ready. On handshake: EMIT->MAC for neuron o+1, or EMIT->IDLE after neuron N_OUT-1.
REQ-014 Weight writes SHALL take effect only in IDLE; w_we in any other state SHALL be ignored.
REQ-015 A w_we in the same IDLE cycle as the first input accept SHALL still be written.
REQ-016 Weights SHALL persist across inferences until rewritten.
REQ-017 An out-of-range w_addr SHALL be ignored.
REQ-018 A sample with in_valid && !in_ready SHALL NOT be stored. The upstream source holds it.

Reset
REQ-019 On reset: state=IDLE, counters=0, out_valid=0, out_data=0, busy=0, in_ready=1 on the first cycle after reset.
REQ-020 Reset mid-LOAD/MAC/EMIT SHALL discard the partial inference without emitting any result.
REQ-021 Weight/bias storage SHALL NOT be cleared by reset. Its contents after power-up are undefined until written.

Configuration
REQ-022 Macro NN_RELU_EN: when defined, each result SHALL pass through ReLU after saturation (negative -> 0).
REQ-023 When NN_RELU_EN is undefined, the saturated result SHALL be output unchanged (linear layer).

Structure
REQ-024 Package nn_pkg SHALL hold the FSM state enum (nn_state_t), the default parameter constants, and a saturate function.
REQ-025 Sub-module nn_mac SHALL provide the single registered multiply-accumulate datapath (clear/load-bias, accumulate, saturate output). nn_layer_seq SHALL hold the FSM, counters, input buffer and weight storage.

Verification (N_IN=4, N_OUT=2, DATA_W=32, FRAC_W=16)
REQ-026 Basic: all weights 0x00010000, bias0 0x00008000, bias1 0; inputs 1,2,3,4 (0x00010000..0x00040000) -> out_data 0x000A8000 then 0x000A0000.
- out_valid first asserts 5 cycles after the 4th accept.
REQ-027 Saturation: W[0][*]=0x7FFF0000, inputs 0x7FFF0000 -> O_1=0x7FFFFFFF. Negating all weights -> O_1=0x80000000.
REQ-028 ReLU: W[0][*]=0xFFFF0000 (-1.0), inputs 1.0, bias 0 -> O_1=0x00000000 with NN_RELU_EN, 0xFFFC0000 without.
REQ-029 Backpressure: out_ready held 0 for 10 cycles in EMIT -> out_data stable, in_ready=0, busy=1. Both results are delivered in order once out_ready=1.
REQ-030 Reset in MAC, then a new inference with basic weights -> only the new results appear (0x000A8000, 0x000A0000), and no stale out_valid.
REQ-031 w_we during MAC with w_data=0 -> no effect. The current and the next inference both give the basic results.
